// File: rtl/aes_keysched_ctrl.sv
// aes_keysched_ctrl: sequences the byte-serial AES round-key datapath and streams round keys 0..Nr.
// Define AES_KS_PERF_CNT_EN to add the saturating stall_cnt backpressure counter.
module aes_keysched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mode_in,
  input  logic [255:0] key_in,
  input  logic         rk_ready,
  input  logic [127:0] round_key,
  output logic [3:0]   RD,
  output logic [1:0]   mode,
  output logic [4:0]   width_sel,
  output logic [127:0] prev_key,
  output logic [127:0] current_key,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         done,
`ifdef AES_KS_PERF_CNT_EN
  output logic         err,
  output logic [15:0]  stall_cnt
`else
  output logic         err
`endif
);
  typedef enum logic [2:0] {IDLE, EMIT0, EMIT1, SUB, COMMIT, OUT, DONE} state_t;
  state_t state, next_state;
  logic [3:0] nr, n_rd, n_idx;
  logic [1:0] n_mode;
  logic [4:0] n_ws;
  logic [127:0] n_prev, n_cur, n_data;
  logic n_valid, n_done, n_err, accept, go;
  assign nr = mode == 2'd2 ? 4'd14 : mode == 2'd1 ? 4'd12 : 4'd10;
  assign accept = rk_valid & rk_ready;
  assign go = state == IDLE & start & mode_in != 2'b11;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      RD          <= '0;
      mode        <= '0;
      width_sel   <= 5'h04;
      prev_key    <= '0;
      current_key <= '0;
      rk_valid    <= 1'b0;
      rk_idx      <= '0;
      rk_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= next_state;
      RD          <= n_rd;
      mode        <= n_mode;
      width_sel   <= n_ws;
      prev_key    <= n_prev;
      current_key <= n_cur;
      rk_valid    <= n_valid;
      rk_idx      <= n_idx;
      rk_data     <= n_data;
      busy        <= next_state != IDLE;
      done        <= n_done;
      err         <= n_err;
    end
  always_comb begin
    next_state = state;
    if (abort) next_state = IDLE;
    else
      case (state)
        IDLE:    next_state = go ? EMIT0 : IDLE;
        EMIT0:   next_state = !accept ? EMIT0 : mode == 2'd2 ? EMIT1 : SUB;
        EMIT1:   next_state = accept ? SUB : EMIT1;
        SUB:     next_state = width_sel == 5'd3 ? COMMIT : SUB;
        COMMIT:  next_state = OUT;
        OUT:     next_state = !accept ? OUT : RD == nr ? DONE : SUB;
        default: next_state = IDLE;
      endcase
  end
  // width_sel parks at 4 everywhere but SUB so a stalled consumer never disturbs the accumulator
  always_comb begin
    n_rd    = RD;
    n_mode  = mode;
    n_prev  = prev_key;
    n_cur   = current_key;
    n_idx   = rk_idx;
    n_data  = rk_data;
    n_ws    = 5'h04;
    n_valid = 1'b0;
    n_done  = 1'b0;
    n_err   = 1'b0;
    if (!abort)
      case (state)
        IDLE: begin
          n_err = start && mode_in == 2'b11;
          if (go) begin
            n_mode  = mode_in;
            n_prev  = mode_in == 2'd2 ? key_in[255:128] : key_in[127:0];
            n_cur   = key_in[127:0];
            n_valid = 1'b1;
            n_idx   = 4'd0;
            n_data  = n_prev;
          end
        end
        EMIT0: begin
          n_valid = !accept || mode == 2'd2;
          if (accept && mode == 2'd2) begin
            n_idx  = 4'd1;
            n_data = current_key;
          end
          if (accept && mode != 2'd2) begin
            n_rd = 4'd1;
            n_ws = 5'd0;
          end
        end
        EMIT1: begin
          n_valid = !accept;
          if (accept) begin
            n_rd = 4'd2;
            n_ws = 5'd0;
          end
        end
        SUB: n_ws = width_sel == 5'd3 ? 5'h04 : width_sel + 5'd1;
        COMMIT: begin
          n_data  = round_key;
          n_idx   = RD;
          n_valid = 1'b1;
          n_prev  = mode == 2'd2 ? current_key : round_key;
          n_cur   = round_key;
        end
        OUT: begin
          n_valid = !accept;
          n_done  = accept && RD == nr;
          if (accept && RD != nr) begin
            n_rd = RD + 4'd1;
            n_ws = 5'd0;
          end
        end
        default: ;
      endcase
  end
`ifdef AES_KS_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n || (go && !abort)) stall_cnt <= '0;
    else if (rk_valid && !rk_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_aes_keysched_ctrl.sv
// tb_aes_keysched_ctrl: drives aes_keysched_ctrl with a behavioural byte-serial datapath and
// checks the round-key stream against a word-level FIPS-197 key expansion model.
module tb_aes_keysched_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, rk_ready = 1'b1;
  logic [1:0] mode_in = '0;
  logic [255:0] key_in = '0;
  logic [127:0] round_key, prev_key, current_key, rk_data;
  logic [3:0] RD, rk_idx;
  logic [1:0] mode;
  logic [4:0] width_sel;
  logic rk_valid, busy, done, err;
`ifdef AES_KS_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, failures = 0;
  logic [7:0] sbox [256];
  logic [7:0] rcon_tab [16];
  logic [127:0] exp_rk [15];

  aes_keysched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_in(mode_in), .key_in(key_in),
    .rk_ready(rk_ready), .round_key(round_key), .RD(RD), .mode(mode), .width_sel(width_sel),
    .prev_key(prev_key), .current_key(current_key), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_data(rk_data), .busy(busy), .done(done),
`ifdef AES_KS_PERF_CNT_EN
    .err(err), .stall_cnt(stall_cnt)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Byte-serial datapath: one S-box lane per SUB cycle, combinational word chain in COMMIT.
  logic [31:0] acc, src, tmp, w0, w1, w2, w3;
  logic odd256;
  always_comb begin
    odd256 = mode == 2'd2 && RD[0];
    src = odd256 ? current_key[31:0] : {current_key[23:0], current_key[31:24]};
    tmp = acc ^ {odd256 ? 8'h00 : rcon_tab[mode == 2'd2 ? {1'b0, RD[3:1]} : RD], 24'h0};
    w0 = prev_key[127:96] ^ tmp;
    w1 = prev_key[95:64] ^ w0;
    w2 = prev_key[63:32] ^ w1;
    w3 = prev_key[31:0] ^ w2;
    round_key = {w0, w1, w2, w3};
  end
  always @(posedge clk)
    if (width_sel < 5'd4) acc[8*(3-int'(width_sel[1:0])) +: 8] <= sbox[src[8*(3-int'(width_sel[1:0])) +: 8]];

  typedef struct {
    logic [1:0] mode;
    logic [255:0] key;
    logic [3:0] stall_idx;
    int stall_len;
    bit rand_ready;
    bit extra_start;
    logic [127:0] last_key;
    int done_cyc;
  } vec_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rl(b) ^ rl(rl(b)) ^ rl(rl(rl(b))) ^ rl(rl(rl(rl(b)))) ^ 8'h63;
    end
    rcon_tab[0] = 8'h00;
    rcon_tab[1] = 8'h01;
    for (int i = 2; i < 16; i++) rcon_tab[i] = xt(rcon_tab[i-1]);
  endtask

  // Word-level key expansion; AES-192 runs the 128-bit recurrence out to 12 rounds.
  task automatic build_ref(input logic [1:0] m, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    nk = m == 2'd2 ? 8 : 4;
    nr = m == 2'd2 ? 14 : m == 2'd1 ? 12 : 10;
    for (int i = 0; i < nk; i++) w[i] = nk == 8 ? k[255-32*i -: 32] : k[127-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_RD"}, 128'(RD), 128'd0);
    chk({tag, "_mode"}, 128'(mode), 128'd0);
    chk({tag, "_width_sel"}, 128'(width_sel), 128'h04);
    chk({tag, "_prev_key"}, prev_key, 128'd0);
    chk({tag, "_current_key"}, current_key, 128'd0);
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'd0);
    chk({tag, "_rk_data"}, rk_data, 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
`ifdef AES_KS_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'd0);
`endif
  endtask

  task automatic run_sched(input string tag, input vec_t v);
    int c, n, stalls, st_used, nr;
    bit seen_done, ws_bad, busy_bad, err_seen, ps;
    logic [127:0] pd;
    logic [3:0] pi;
    nr = v.mode == 2'd2 ? 14 : v.mode == 2'd1 ? 12 : 10;
    build_ref(v.mode, v.key);
    {n, stalls, st_used, seen_done, ws_bad, busy_bad, err_seen, ps} = '0;
    pd = '0;
    pi = '0;
    start = 1'b1;
    mode_in = v.mode;
    key_in = v.key;
    rk_ready = 1'b1;
    tick();
    start = 1'b0;
    key_in = rand256();
    c = 0;
    while (c < 400) begin
      c++;
      if (err) err_seen = 1'b1;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (rk_valid && width_sel != 5'h04) ws_bad = 1'b1;
      if (rk_valid && ps) begin
        chk({tag, "_stall_data_stable"}, rk_data, pd);
        chk({tag, "_stall_idx_stable"}, 128'(rk_idx), 128'(pi));
      end
      start = v.extra_start && (c == 10 || c == 30);
      if (start) begin
        mode_in = 2'($urandom_range(0, 3));
        key_in = rand256();
      end
      rk_ready = !(rk_valid && rk_idx == v.stall_idx && st_used < v.stall_len) &&
                 !(v.rand_ready && $urandom_range(0, 2) == 0);
      if (rk_valid && rk_ready) begin
        chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(n));
        chk({tag, "_rk_data"}, rk_data, exp_rk[n]);
        if (n >= (v.mode == 2'd2 ? 2 : 1)) chk({tag, "_RD"}, 128'(RD), 128'(n));
        if (n == nr && v.last_key != '0) chk({tag, "_fips_last_key"}, rk_data, v.last_key);
        n++;
      end else if (rk_valid) begin
        stalls++;
        if (rk_idx == v.stall_idx) st_used++;
      end
      ps = rk_valid && !rk_ready;
      pd = rk_data;
      pi = rk_idx;
      tick();
    end
    start = 1'b0;
    rk_ready = 1'b1;
    chk({tag, "_done_cycle"}, 128'(seen_done ? c : 9999), 128'(v.done_cyc + (v.rand_ready ? stalls : 0)));
    chk({tag, "_key_count"}, 128'(n), 128'(nr + 1));
    chk({tag, "_width_sel_while_valid"}, 128'(ws_bad), 128'd0);
    chk({tag, "_busy_drop"}, 128'(busy_bad), 128'd0);
    chk({tag, "_spurious_err"}, 128'(err_seen), 128'd0);
`ifdef AES_KS_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(stalls));
`endif
    tick();
    chk({tag, "_idle_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done_pulse"}, 128'(done), 128'd0);
  endtask

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] L128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] L256 = 128'hfe4890d1e6188d0b046df344706c631e;

  initial begin
    vec_t tbl [7];
    vec_t rv;
    bit seen;
    int m;
    init_tables();
    tbl[0] = '{2'd0, K128, 4'd0, 0, 1'b0, 1'b0, L128, 62};
    tbl[1] = '{2'd2, K256, 4'd0, 0, 1'b0, 1'b0, L256, 81};
    tbl[2] = '{2'd0, K128, 4'd5, 3, 1'b0, 1'b0, L128, 65};
    tbl[3] = '{2'd0, rand256(), 4'd0, 0, 1'b0, 1'b1, 128'd0, 62};
    tbl[4] = '{2'd1, rand256(), 4'd0, 0, 1'b0, 1'b0, 128'd0, 74};
    tbl[5] = '{2'd2, rand256(), 4'd0, 0, 1'b1, 1'b1, 128'd0, 81};
    tbl[6] = '{2'd0, K128, 4'd0, 0, 1'b1, 1'b0, L128, 62};
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_reset_idle");

    start = 1'b1;
    mode_in = 2'b11;
    key_in = K128;
    tick();
    start = 1'b0;
    chk("illegal_err", 128'(err), 128'd1);
    chk("illegal_busy", 128'(busy), 128'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | rk_valid | err;
    end
    chk("illegal_no_valid_no_err", 128'(seen), 128'd0);

    start = 1'b1;
    mode_in = 2'd0;
    key_in = K128;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      seen = RD == 4'd4 && width_sel == 5'd1;
      if (!seen) tick();
    end
    chk("abort_reach_round4_sub", 128'(seen), 128'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_valid", 128'(rk_valid), 128'd0);
    chk("abort_width_sel", 128'(width_sel), 128'h04);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | done | rk_valid;
    end
    chk("abort_no_done", 128'(seen), 128'd0);

    for (int i = 0; i < 7; i++) run_sched($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      m = $urandom_range(0, 2);
      rv = '{2'(m), rand256(), 4'd0, 0, 1'b1, 1'b0, 128'd0, m == 2 ? 81 : 6 * (m == 1 ? 12 : 10) + 2};
      run_sched($sformatf("rand%0d", i), rv);
    end

    start = 1'b1;
    mode_in = 2'd2;
    key_in = K256;
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("pre_reset_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_reset");
    rst_n = 1'b1;
    tick();
    chk("after_reset_busy", 128'(busy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_keysched_ctrl.md
# aes_keysched_ctrl

Sequencer for the byte-serial AES forward round-key datapath (`aes_roundkey`). Given a cipher key and mode, it drives `RD`, `mode`, `width_sel`, `prev_key` and `current_key` through four S-box byte sub-rounds and one commit cycle per round. It captures each `round_key` and streams round keys 0..Nr to a consumer over a valid/ready handshake. It sits between the key-load interface and the key store / cipher round engine.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a schedule; sampled only in IDLE.
- `abort` in 1: return to IDLE next cycle from any state.
- `mode_in` in 2: 00 AES-128, 01 AES-192, 10 AES-256, 11 illegal.
- `key_in` in 256: cipher key, sampled with `start`; AES-128/192 use [127:0].
- `rk_ready` in 1: consumer accepts the round key.
- `round_key` in 128: from the datapath.
- `RD` out 4: round number to the datapath.
- `mode` out 2: registered copy of `mode_in`.
- `width_sel` out 5: byte-lane select / accumulate enable to the datapath.
- `prev_key` out 128, `current_key` out 128: datapath key operands.
- `rk_valid` out 1, `rk_idx` out 4, `rk_data` out 128: round-key stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last key is accepted.
- `err` out 1: one-cycle pulse when `start` arrives with `mode_in`=11.

## Operation
- Nr = 10 / 12 / 14 for modes 00 / 01 / 10. AES-192 uses the AES-128 sequence with Nr=12.
- **IDLE**
  - `width_sel`=5'h04 (accumulator disabled).
  - On `start` with a legal mode: register `mode`.
    - AES-128/192: `current_key`=`prev_key`=`key_in[127:0]`.
    - AES-256: `prev_key`=`key_in[255:128]`, `current_key`=`key_in[127:0]`.
    - Go to EMIT0.
  - On `start` with mode 11: pulse `err` and stay in IDLE.
- **EMIT0**
  - `rk_valid`=1, `rk_idx`=0.
  - `rk_data` = `key_in[127:0]` (128/192) or `key_in[255:128]` (256).
  - On accept: 256 → EMIT1; otherwise `RD`=1 → SUB.
- **EMIT1** (256 only)
  - `rk_idx`=1, `rk_data`=`key_in[127:0]`.
  - On accept: `RD`=2 → SUB.
- **SUB**
  - `width_sel` = 0,1,2,3 on four consecutive cycles, then COMMIT.
- **COMMIT**
  - `width_sel`=5'h04; the accumulator holds.
  - Capture `round_key` into `rk_data`.
  - Update operands:
    - 128/192: `prev_key`,`current_key` ← `round_key`.
    - 256: `prev_key` ← `current_key`, `current_key` ← `round_key`.
  - Go to OUT.
- **OUT**
  - `rk_valid`=1, `rk_idx`=`RD`; hold until `rk_ready`.
  - On accept: if `RD`==Nr → DONE; else `RD`+1 → SUB.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- `rk_data`/`rk_idx` remain stable while `rk_valid`=1 and `rk_ready`=0.
- `start` while `busy` is ignored. `key_in` changes after sampling have no effect.
- `abort` has priority over every transition. No `done` is raised; `rk_valid` drops on the next cycle.
- `rst_n` low mid-schedule behaves like `abort`, and in addition all outputs return to their reset values.

## Timing
- Reset values: `RD`=0, `mode`=0, `width_sel`=5'h04, keys 0, `rk_valid`=0, `rk_idx`=0, `rk_data`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered.
- With `start` at edge 0 and `rk_ready` held at 1:
  - EMIT0 is on cycle 1.
  - Each round takes 6 cycles (4 SUB, 1 COMMIT, 1 OUT).
  - AES-128: last OUT on cycle 61, `done` on cycle 62.
  - AES-256: EMIT1 on cycle 2, last OUT on cycle 80, `done` on cycle 81.
- Each `rk_ready`=0 cycle in EMIT/OUT adds exactly one cycle.
- `width_sel` is never 0..3 outside SUB, so the accumulator is never disturbed while stalled.

## Configuration
- `AES_KS_PERF_CNT_EN` defined:
  - Adds output `stall_cnt` (16 bits): counts cycles with `rk_valid`=1 and `rk_ready`=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by accepted `start`.
- `AES_KS_PERF_CNT_EN` undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- **AES-128 FIPS-197 key** 2b7e1516…09cf4f3c, `rk_ready`=1:
  - 11 keys, idx 0..10.
  - idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` on cycle 62.
- **AES-256 FIPS-197 key** 603deb10…0914dff4:
  - idx 0/1 equal the key halves.
  - idx 14 = fe4890d1e6188d0b046df344706c631e.
  - `RD` sweeps 2..14; `done` on cycle 81.
- **Backpressure:** `rk_ready` low 3 cycles at idx 5 (AES-128):
  - `rk_data` stable; `width_sel`=5'h04 throughout.
  - `done` on cycle 65; `stall_cnt`=3 when enabled.
- **Illegal mode:** `start` with `mode_in`=11 → `err` pulse, `busy`=0, `rk_valid` never asserted.
- **Abort:** `abort` during SUB of round 4 → IDLE next cycle, no `done`. A new `start` then yields a correct full schedule.
- **Start while busy / reset:**
  - Extra `start` pulses mid-schedule are ignored and the key sequence is unchanged.
  - `rst_n`=0 on cycle 30 → all outputs at reset values on the next cycle.
